ame_pivot_search: RTL
=====================

Name: ame_pivot_search

Overview:
- Sequential, parametrised magnitude search for elimination pivots.
- Streams a column of values as beats of COMP_LANES words each; masked lanes are excluded from the search.
- Tracks the running maximum (or minimum) magnitude across beats and reports the winning word, its global row index and status flags.
- Sits between the column-fetch logic and the row-swap/normalise stage of the ame datapath.

Parameters:
- COMP_DATA_BITS, 64: width of each stored word.
- COMP_ABS_BITS, 48: low bits of each word treated as a two's-complement value for magnitude.
- COMP_LANES, 6: words per beat (>= 2).
- COMP_BEATS_MAX, 8: maximum beats per search (>= 1).
- COMP_DATA_IDX_BITS, $clog2(COMP_LANES*COMP_BEATS_MAX): width of the global row index.

Ports:
- clk_i, in, 1: clock.
- rst_n_i, in, 1: asynchronous active-low reset.
- comp_init_i, in, 1: start pulse; clears the accumulator and begins a search.
- comp_min_i, in, 1: sampled at init; 0 = max magnitude, 1 = min magnitude.
- comp_valid_i, in, 1: beat valid.
- comp_ready_o, out, 1: beat accepted when valid && ready.
- comp_last_i, in, 1: final beat of the search.
- comp_data_i, in, [COMP_LANES-1:0][COMP_DATA_BITS-1:0]: beat words.
- comp_data_mask_i, in, [COMP_LANES-1:0]: 1 = lane excluded.
- comp_done_o, out, 1: one-cycle result-valid pulse.
- comp_data_o, out, COMP_DATA_BITS: full original word of the winner.
- comp_data_index_o, out, COMP_DATA_IDX_BITS: winner index = beat*COMP_LANES + lane.
- comp_none_o, out, 1: all lanes in all beats were masked.
- comp_ovf_o, out, 1: search was force-terminated at COMP_BEATS_MAX.

Behaviour:
- Reset: state IDLE. comp_ready_o=0, comp_done_o=0, comp_data_o=0, comp_data_index_o=0, comp_none_o=0, comp_ovf_o=0. Accumulator invalid, beat counter 0.
- Magnitude: m = x[ABS-1] ? (-x[ABS-1:0]) mod 2^ABS : x[ABS-1:0], compared as unsigned. The most negative value therefore has magnitude 2^(ABS-1).
- Comparison: masked lanes never win. Ties resolve to the lowest global index, both within a beat and across beats; a later beat replaces the accumulator only on a strict improvement.
- Pipeline:
  - Stage 1 (accept cycle): magnitudes and the lane-reduction tree are combinational; the register captures the beat best magnitude, word, lane, beat number, valid (any unmasked lane) and last.
  - Stage 2: merge with the accumulator.
  - comp_done_o asserts exactly 2 cycles after the accept cycle of the last beat.
- State machine:
  - IDLE: ready=0. comp_init_i -> RUN.
  - RUN: ready=1. An accepted beat with comp_last_i=1, or the accepted beat with counter = COMP_BEATS_MAX-1 (which sets ovf), moves to DRAIN.
  - DRAIN: ready=0 for one cycle while stage 2 completes, then -> DONE.
  - DONE: comp_done_o=1 for one cycle, outputs updated in the same cycle, then -> IDLE.
- Outputs hold their values until the next DONE. comp_none_o=1 forces comp_data_o=0 and comp_data_index_o=0.
- comp_init_i in RUN/DRAIN aborts the search: accumulator, counter and ovf are cleared, the state restarts in RUN next cycle and no done pulse is issued for the aborted search.
- comp_init_i in DONE is ignored.
- Beats with comp_valid_i=0 are bubbles; the counter does not advance.
- comp_valid_i while not ready is ignored. There is no back-pressure on the outputs.
- Async reset mid-search: immediate return to the reset state; any partial result is discarded.

Test Plan:
- LANES=6, BEATS_MAX=4, max mode, one beat {5,-9,3,9,0,1}, no mask, last -> done 2 cycles after accept, index 1 (-9 beats 9 on tie), data -9.
- Two beats {1,2,3,4,5,6} then {0,0,0x7,0,0,6} with last -> index 8, data 7. A third search repeating 6 in beat 2 lane 5 -> index 5 (tie keeps earlier).
- Min mode, {8,-2,4,2,M,M} with mask 6'b110000 -> index 1, data -2. Masked lanes holding 0 must not win.
- All lanes masked in both beats -> comp_none_o=1, data 0, index 0.
- 4 beats without last -> forced DRAIN after beat 3, comp_ovf_o=1, ready low from the next cycle. Also inject a value 0x800000000000 -> magnitude 2^47 wins.
- comp_init_i mid-RUN after one beat holding value 100, then a beat {1,0,0,0,0,0} with last -> single done pulse with index 0, data 1. Separately, assert rst_n_i low in DRAIN -> all outputs 0 immediately and no done pulse.

Source files
------------

// File: rtl/ame_pivot_search.sv
// Streaming pivot search: finds the max/min magnitude word across masked multi-lane beats.
// Stage 1 reduces a beat to its best lane; stage 2 merges that into the running accumulator.
module ame_pivot_search #(
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_ABS_BITS      = 48,
    parameter int COMP_LANES         = 6,
    parameter int COMP_BEATS_MAX     = 8,
    parameter int COMP_DATA_IDX_BITS = $clog2(COMP_LANES * COMP_BEATS_MAX)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    input  logic                                     comp_init_i,
    input  logic                                     comp_min_i,
    input  logic                                     comp_valid_i,
    output logic                                     comp_ready_o,
    input  logic                                     comp_last_i,
    input  logic [COMP_LANES-1:0][COMP_DATA_BITS-1:0] comp_data_i,
    input  logic [COMP_LANES-1:0]                    comp_data_mask_i,
    output logic                                     comp_done_o,
    output logic [COMP_DATA_BITS-1:0]                comp_data_o,
    output logic [COMP_DATA_IDX_BITS-1:0]            comp_data_index_o,
    output logic                                     comp_none_o,
    output logic                                     comp_ovf_o
);

    localparam int CNT_BITS = $clog2(COMP_BEATS_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                        state_q, state_d;
    logic                          min_q, min_d;
    logic [CNT_BITS-1:0]           cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;

    logic                          s1_vld_q, s1_vld_d;
    logic                          s1_any_q, s1_any_d;
    logic [COMP_ABS_BITS-1:0]      s1_mag_q, s1_mag_d;
    logic [COMP_DATA_BITS-1:0]     s1_word_q, s1_word_d;
    logic [COMP_DATA_IDX_BITS-1:0] s1_idx_q, s1_idx_d;

    logic                          acc_vld_q, acc_vld_d;
    logic [COMP_ABS_BITS-1:0]      acc_mag_q, acc_mag_d;
    logic [COMP_DATA_BITS-1:0]     acc_word_q, acc_word_d;
    logic [COMP_DATA_IDX_BITS-1:0] acc_idx_q, acc_idx_d;

    logic [COMP_DATA_BITS-1:0]     out_data_q, out_data_d;
    logic [COMP_DATA_IDX_BITS-1:0] out_idx_q, out_idx_d;
    logic                          out_none_q, out_none_d;
    logic                          out_ovf_q, out_ovf_d;

    logic                          accept;
    logic                          b_any;
    logic [COMP_ABS_BITS-1:0]      b_mag;
    logic [COMP_ABS_BITS-1:0]      lane_mag;
    logic [COMP_DATA_BITS-1:0]     b_word;
    logic [COMP_DATA_IDX_BITS-1:0] b_idx;
    logic [COMP_DATA_IDX_BITS-1:0] beat_base;

    function automatic logic [COMP_ABS_BITS-1:0] mag_f(input logic [COMP_ABS_BITS-1:0] x);
        return x[COMP_ABS_BITS-1] ? ('0 - x) : x;
    endfunction

    // Strict comparison so that equal magnitudes keep the earlier (lower-index) candidate.
    function automatic logic better_f(input logic [COMP_ABS_BITS-1:0] a,
                                      input logic [COMP_ABS_BITS-1:0] b,
                                      input logic                     use_min);
        return use_min ? (a < b) : (a > b);
    endfunction

    assign comp_ready_o      = (state_q == ST_RUN);
    assign comp_done_o       = (state_q == ST_DONE);
    assign comp_data_o       = out_data_q;
    assign comp_data_index_o = out_idx_q;
    assign comp_none_o       = out_none_q;
    assign comp_ovf_o        = out_ovf_q;

    assign accept    = (state_q == ST_RUN) && comp_valid_i && !comp_init_i;
    assign beat_base = COMP_DATA_IDX_BITS'(cnt_q) * COMP_DATA_IDX_BITS'(COMP_LANES);

    always_comb begin
        b_any    = 1'b0;
        b_mag    = '0;
        b_word   = '0;
        b_idx    = '0;
        lane_mag = '0;
        for (int unsigned l = 0; l < COMP_LANES; l++) begin
            lane_mag = mag_f(comp_data_i[l][COMP_ABS_BITS-1:0]);
            if (!comp_data_mask_i[l] && (!b_any || better_f(lane_mag, b_mag, min_q))) begin
                b_any  = 1'b1;
                b_mag  = lane_mag;
                b_word = comp_data_i[l];
                b_idx  = beat_base + COMP_DATA_IDX_BITS'(l);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        s1_vld_d   = accept;
        s1_any_d   = s1_any_q;
        s1_mag_d   = s1_mag_q;
        s1_word_d  = s1_word_q;
        s1_idx_d   = s1_idx_q;
        acc_vld_d  = acc_vld_q;
        acc_mag_d  = acc_mag_q;
        acc_word_d = acc_word_q;
        acc_idx_d  = acc_idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_none_d = out_none_q;
        out_ovf_d  = out_ovf_q;

        if (accept) begin
            s1_any_d  = b_any;
            s1_mag_d  = b_mag;
            s1_word_d = b_word;
            s1_idx_d  = b_idx;
        end

        if (s1_vld_q && s1_any_q && (!acc_vld_q || better_f(s1_mag_q, acc_mag_q, min_q))) begin
            acc_vld_d  = 1'b1;
            acc_mag_d  = s1_mag_q;
            acc_word_d = s1_word_q;
            acc_idx_d  = s1_idx_q;
        end

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_DRAIN: begin
                if (comp_init_i) begin
                    // Start or abort: anything still in flight is dropped.
                    state_d   = ST_RUN;
                    min_d     = comp_min_i;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    s1_vld_d  = 1'b0;
                    acc_vld_d = 1'b0;
                end else if (state_q == ST_RUN) begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                        if (comp_last_i) begin
                            state_d = ST_DRAIN;
                        end else if (cnt_q == CNT_BITS'(COMP_BEATS_MAX - 1)) begin
                            state_d = ST_DRAIN;
                            ovf_d   = 1'b1;
                        end
                    end
                end else if (state_q == ST_DRAIN) begin
                    state_d    = ST_DONE;
                    out_none_d = !acc_vld_d;
                    out_ovf_d  = ovf_q;
                    out_data_d = acc_vld_d ? acc_word_d : '0;
                    out_idx_d  = acc_vld_d ? acc_idx_d : '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            min_q      <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_any_q   <= 1'b0;
            s1_mag_q   <= '0;
            s1_word_q  <= '0;
            s1_idx_q   <= '0;
            acc_vld_q  <= 1'b0;
            acc_mag_q  <= '0;
            acc_word_q <= '0;
            acc_idx_q  <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_none_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            s1_vld_q   <= s1_vld_d;
            s1_any_q   <= s1_any_d;
            s1_mag_q   <= s1_mag_d;
            s1_word_q  <= s1_word_d;
            s1_idx_q   <= s1_idx_d;
            acc_vld_q  <= acc_vld_d;
            acc_mag_q  <= acc_mag_d;
            acc_word_q <= acc_word_d;
            acc_idx_q  <= acc_idx_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_none_q <= out_none_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule
